// File: rtl/fwd_scoreboard_unit.sv
// Scoreboard-based forwarding/load-use unit: tracks in-flight writes over NUM_STAGES post-EX stages.
// Optional macro FWD_STALL_COUNTER_EN adds a saturating stall-cycle counter output o_stall_count.
module fwd_scoreboard_unit #(
  parameter int REG_SIZE     = 5,
  parameter int NUM_STAGES   = 3,
  parameter int SELECT_SIZE  = 2,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [REG_SIZE-1:0]    i_id_rs,
  input  logic [REG_SIZE-1:0]    i_id_rt,
  input  logic                   i_id_uses_rs,
  input  logic                   i_id_uses_rt,
  input  logic [REG_SIZE-1:0]    i_ex_rd,
  input  logic                   i_ex_write_reg,
  input  logic                   i_ex_mem_read,
  input  logic                   i_flush,
  output logic [SELECT_SIZE-1:0] o_forwarding_a,
  output logic [SELECT_SIZE-1:0] o_forwarding_b,
`ifdef FWD_STALL_COUNTER_EN
  output logic [15:0]            o_stall_count,
`endif
  output logic                   o_stall
);

  if ((2 ** SELECT_SIZE) < (NUM_STAGES + 1)) begin : g_bad_select_size
    $error("fwd_scoreboard_unit: SELECT_SIZE too narrow for NUM_STAGES");
  end
  if ((LOAD_LATENCY < 0) || (LOAD_LATENCY >= NUM_STAGES)) begin : g_bad_load_latency
    $error("fwd_scoreboard_unit: LOAD_LATENCY out of range");
  end

  logic                   sb_wr_r   [NUM_STAGES];
  logic [REG_SIZE-1:0]    sb_rd_r   [NUM_STAGES];
  logic                   sb_ld_r   [NUM_STAGES];

  // Candidate i is the producer that will sit in stage i next cycle; its select code is i+1.
  logic                   cand_wr_s [NUM_STAGES];
  logic [REG_SIZE-1:0]    cand_rd_s [NUM_STAGES];
  logic                   cand_ld_s [NUM_STAGES];

  logic [SELECT_SIZE-1:0] sel_a_s;
  logic [SELECT_SIZE-1:0] sel_b_s;
  logic                   ld_a_s;
  logic                   ld_b_s;
  logic                   stall_s;

  // Gather producers in youngest-first order as they will be positioned next cycle.
  always_comb begin
    cand_wr_s[0] = i_ex_write_reg && (i_ex_rd != {REG_SIZE{1'b0}});
    cand_rd_s[0] = i_ex_rd;
    cand_ld_s[0] = i_ex_mem_read;
    for (int i = 1; i < NUM_STAGES; i++) begin
      cand_wr_s[i] = sb_wr_r[i-1];
      cand_rd_s[i] = sb_rd_r[i-1];
      cand_ld_s[i] = sb_ld_r[i-1];
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_a_s = {SELECT_SIZE{1'b0}};
    sel_b_s = {SELECT_SIZE{1'b0}};
    ld_a_s  = 1'b0;
    ld_b_s  = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i_id_uses_rs && cand_wr_s[i] && (cand_rd_s[i] == i_id_rs)) begin
        sel_a_s = SELECT_SIZE'(i + 1);
        ld_a_s  = cand_ld_s[i] && (i < LOAD_LATENCY);
      end else begin
        sel_a_s = sel_a_s;
        ld_a_s  = ld_a_s;
      end
      if (i_id_uses_rt && cand_wr_s[i] && (cand_rd_s[i] == i_id_rt)) begin
        sel_b_s = SELECT_SIZE'(i + 1);
        ld_b_s  = cand_ld_s[i] && (i < LOAD_LATENCY);
      end else begin
        sel_b_s = sel_b_s;
        ld_b_s  = ld_b_s;
      end
    end
  end

  // Load-use stall: youngest producer is a load whose result is not forwardable yet.
  always_comb begin
    if (i_id_valid && !i_flush && !i_reset) begin
      stall_s = ld_a_s || ld_b_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign o_stall = stall_s;

  // Scoreboard shift: runs every cycle, stall or not.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb_wr_r[i] <= 1'b0;
        sb_rd_r[i] <= {REG_SIZE{1'b0}};
        sb_ld_r[i] <= 1'b0;
      end
    end else begin
      sb_wr_r[0] <= i_ex_write_reg && (i_ex_rd != {REG_SIZE{1'b0}});
      sb_rd_r[0] <= i_ex_rd;
      sb_ld_r[0] <= i_ex_mem_read;
      for (int i = 1; i < NUM_STAGES; i++) begin
        sb_wr_r[i] <= sb_wr_r[i-1];
        sb_rd_r[i] <= sb_rd_r[i-1];
        sb_ld_r[i] <= sb_ld_r[i-1];
      end
    end
  end

  // Forwarding selects travel with the instruction from ID into EX.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush || stall_s || !i_id_valid) begin
      o_forwarding_a <= {SELECT_SIZE{1'b0}};
      o_forwarding_b <= {SELECT_SIZE{1'b0}};
    end else begin
      o_forwarding_a <= sel_a_s;
      o_forwarding_b <= sel_b_s;
    end
  end

`ifdef FWD_STALL_COUNTER_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_count <= 16'h0000;
    end else if (stall_s && (o_stall_count != 16'hFFFF)) begin
      o_stall_count <= o_stall_count + 16'h0001;
    end else begin
      o_stall_count <= o_stall_count;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit: age-history model checked every cycle plus literal expectations.
module tb_fwd_scoreboard_unit;
  localparam int NS = 3;
  localparam int LL = 1;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_id_valid = 1'b0;
  logic [4:0] i_id_rs = 5'd0;
  logic [4:0] i_id_rt = 5'd0;
  logic       i_id_uses_rs = 1'b0;
  logic       i_id_uses_rt = 1'b0;
  logic [4:0] i_ex_rd = 5'd0;
  logic       i_ex_write_reg = 1'b0;
  logic       i_ex_mem_read = 1'b0;
  logic       i_flush = 1'b0;
  logic [1:0] o_forwarding_a;
  logic [1:0] o_forwarding_b;
  logic       o_stall;
`ifdef FWD_STALL_COUNTER_EN
  logic [15:0] o_stall_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  fwd_scoreboard_unit dut (
    .i_clk(clk), .i_reset(i_reset), .i_id_valid(i_id_valid),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rs(i_id_uses_rs), .i_id_uses_rt(i_id_uses_rt),
    .i_ex_rd(i_ex_rd), .i_ex_write_reg(i_ex_write_reg), .i_ex_mem_read(i_ex_mem_read),
    .i_flush(i_flush), .o_forwarding_a(o_forwarding_a), .o_forwarding_b(o_forwarding_b),
`ifdef FWD_STALL_COUNTER_EN
    .o_stall_count(o_stall_count),
`endif
    .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of past EX writes, youngest first; index k = cycles since it left EX.
  typedef struct { bit wr; logic [4:0] rd; bit ld; } ent_t;
  ent_t hist[$];
  logic [1:0]  exp_fa = 2'd0;
  logic [1:0]  exp_fb = 2'd0;
  logic [15:0] exp_cnt = 16'd0;

  function automatic void youngest(input logic [4:0] src, input bit uses, output int code, output bit lstall);
    ent_t p[$];
    ent_t cur;
    code = 0;
    lstall = 1'b0;
    cur.wr = i_ex_write_reg && (i_ex_rd != 5'd0);
    cur.rd = i_ex_rd;
    cur.ld = i_ex_mem_read;
    p = hist;
    p.push_front(cur);
    for (int k = 0; k < p.size() && k < NS; k++) begin
      if (uses && p[k].wr && p[k].rd == src) begin
        code = k + 1;
        lstall = p[k].ld && (k < LL);
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    int ca, cb;
    bit la, lb, st;
    ent_t e;
    st = 1'b0; ca = 0; cb = 0;
    if (!i_reset) begin
      youngest(i_id_rs, i_id_uses_rs, ca, la);
      youngest(i_id_rt, i_id_uses_rt, cb, lb);
      st = i_id_valid && !i_flush && (la || lb);
    end
    chk("model_stall", {31'd0, o_stall}, {31'd0, st});
    chk("model_fwd_a", {30'd0, o_forwarding_a}, {30'd0, exp_fa});
    chk("model_fwd_b", {30'd0, o_forwarding_b}, {30'd0, exp_fb});
`ifdef FWD_STALL_COUNTER_EN
    chk("model_count", {16'd0, o_stall_count}, {16'd0, exp_cnt});
`endif
    if (i_reset || i_flush || st || !i_id_valid) begin
      exp_fa = 2'd0; exp_fb = 2'd0;
    end else begin
      exp_fa = 2'(ca); exp_fb = 2'(cb);
    end
    if (i_reset) begin
      hist.delete();
      exp_cnt = 16'd0;
    end else begin
      e.wr = i_ex_write_reg && (i_ex_rd != 5'd0);
      e.rd = i_ex_rd;
      e.ld = i_ex_mem_read;
      hist.push_front(e);
      if (hist.size() > NS) void'(hist.pop_back());
      if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic drive(input logic [4:0] erd, input logic ewr, input logic eld, input logic iv,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic fl);
    @(posedge clk); #1;
    i_reset = 1'b0;
    i_ex_rd = erd; i_ex_write_reg = ewr; i_ex_mem_read = eld;
    i_id_valid = iv; i_id_rs = rs; i_id_rt = rt;
    i_id_uses_rs = urs; i_id_uses_rt = urt; i_flush = fl;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_stall", {31'd0, o_stall}, 32'd0);
    chk("reset_fwd_a", {30'd0, o_forwarding_a}, 32'd0);

    // Simple forward from EX
    drive(5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("simple_stall", {31'd0, o_stall}, 32'd0);
    idle();
    #1 chk("simple_fwd_a", {30'd0, o_forwarding_a}, 32'd1);
    chk("simple_fwd_b", {30'd0, o_forwarding_b}, 32'd0);

    // Youngest wins: EX over stage 0
    drive(5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0);
    idle();
    #1 chk("youngest_ex", {30'd0, o_forwarding_b}, 32'd1);
    // Same with EX not writing: stage 0 supplies it
    drive(5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0);
    idle();
    #1 chk("youngest_stage0", {30'd0, o_forwarding_b}, 32'd2);

    // Producer two cycles back lands in stage 2 next cycle: code 3
    repeat (3) idle();
    drive(5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    drive(5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    #1 chk("stage1_code3", {30'd0, o_forwarding_a}, 32'd3);

    // Load-use: one stall cycle, then forward from stage 1 (code 2)
    repeat (3) idle();
    drive(5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall", {31'd0, o_stall}, 32'd1);
    drive(5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall_clear", {31'd0, o_stall}, 32'd0);
    chk("lu_fwd_b_bubble", {30'd0, o_forwarding_b}, 32'd0);
    idle();
    #1 chk("lu_fwd_b", {30'd0, o_forwarding_b}, 32'd2);

    // Younger non-load masks older load
    repeat (3) idle();
    drive(5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("mask_stall", {31'd0, o_stall}, 32'd0);
    idle();
    #1 chk("mask_fwd_a", {30'd0, o_forwarding_a}, 32'd1);

    // rs == rt: both selects match, single stall
    repeat (3) idle();
    drive(5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    idle();
    #1 chk("same_fwd_a", {30'd0, o_forwarding_a}, 32'd1);
    chk("same_fwd_b", {30'd0, o_forwarding_b}, 32'd1);
    drive(5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
    #1 chk("same_stall", {31'd0, o_stall}, 32'd1);

    // Register zero never forwards or stalls
    repeat (3) idle();
    drive(5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("zero_stall", {31'd0, o_stall}, 32'd0);
    idle();
    #1 chk("zero_fwd_a", {30'd0, o_forwarding_a}, 32'd0);

    // Flush suppresses stall and selects
    repeat (3) idle();
    drive(5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    #1 chk("flush_stall", {31'd0, o_stall}, 32'd0);
    idle();
    #1 chk("flush_fwd_b", {30'd0, o_forwarding_b}, 32'd0);

    // Reset during an active stall
    repeat (3) idle();
    drive(5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("pre_reset_stall", {31'd0, o_stall}, 32'd1);
    i_reset = 1'b1;
    #1 chk("reset_drops_stall", {31'd0, o_stall}, 32'd0);
    drive(5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 chk("post_reset_stall", {31'd0, o_stall}, 32'd0);
    idle();
    #1 chk("post_reset_fwd_a", {30'd0, o_forwarding_a}, 32'd0);

`ifdef FWD_STALL_COUNTER_EN
    @(posedge clk); #1 i_reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive(5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
      drive(5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
      repeat (3) idle();
    end
    #1 chk("count_3", {16'd0, o_stall_count}, 32'd3);
    drive(5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    idle();
    #1 chk("count_sat", {16'd0, o_stall_count}, 32'h0000FFFF);
`endif

    repeat (3) idle();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
